// File: rtl/ifetch.sv
// ifetch: instruction fetch stage of the pako32 core.
// Owns the PC, fetches one word per request/grant/rvalid handshake, presents it
// to decode, and follows the control stage's next-PC select.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (trap on misaligned next PC).
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic [1:0]  pc_next_sel_i,
    input  logic [31:0] pc_next_off_i,
    input  logic [31:0] pc_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_data_o,
    output logic        instr_valid_o,
    output logic [31:0] fetch_cnt_o,
    output logic        trap_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0] PC_NEXT_SEL_STALL  = 2'd0;
    localparam logic [1:0] PC_NEXT_SEL_PC_IMM = 2'd1;
    localparam logic [1:0] PC_NEXT_SEL_ABS    = 2'd2;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_REQ,
        ST_WAIT,
        ST_VALID,
        ST_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_d, data_d, cnt_d, pc_calc;
    logic        req_d, valid_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic        trap_d;
`endif

    // The fetch address is the PC itself; no separate address register.
    assign imem_addr_o = pc_o;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_o;
        data_d  = pc_data_o;
        cnt_d   = fetch_cnt_o;
        valid_d = instr_valid_o;
        pc_calc = pc_o;
`ifdef IFETCH_MISALIGN_TRAP_EN
        trap_d  = trap_o;
`endif
        case (state_q)
            ST_RESET: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    data_d  = imem_rdata_i;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end
            end
            ST_VALID: begin
                // STALL and the unused encoding 3 both hold everything.
                if (pc_next_sel_i == PC_NEXT_SEL_PC_IMM || pc_next_sel_i == PC_NEXT_SEL_ABS) begin
                    pc_calc = (pc_next_sel_i == PC_NEXT_SEL_PC_IMM) ? pc_o + pc_next_off_i
                                                                     : pc_target_i & ~32'h1;
                    cnt_d   = fetch_cnt_o + 32'd1;
                    valid_d = 1'b0;
                    data_d  = NOP;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    pc_d = pc_calc;
                    if (pc_calc[1:0] != 2'b00) begin
                        trap_d  = 1'b1;
                        state_d = ST_TRAP;
                    end else begin
                        state_d = ST_REQ;
                    end
`else
                    pc_d    = pc_calc & ~32'h3;
                    state_d = ST_REQ;
`endif
                end
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RESET;
        endcase
        // Request is high exactly while sitting in ST_REQ; address held until grant.
        req_d = (state_d == ST_REQ);
    end

    // State and output registers; reset drops any outstanding response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= ST_RESET;
            pc_o          <= RESET_PC;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
            pc_data_o     <= NOP;
            fetch_cnt_o   <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_o          <= pc_d;
            imem_req_o    <= req_d;
            instr_valid_o <= valid_d;
            pc_data_o     <= data_d;
            fetch_cnt_o   <= cnt_d;
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) trap_o <= 1'b0;
        else         trap_o <= trap_d;
    end
`else
    assign trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed + randomized bench for ifetch with an in-bench memory
// driver and a PC/counter reference model derived from the fetch rules.
module tb_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [1:0]  pc_next_sel_i = 2'd0;
    logic [31:0] pc_next_off_i = 32'h0;
    logic [31:0] pc_target_i = 32'h0;
    logic [31:0] pc_o;
    logic [31:0] pc_data_o;
    logic        instr_valid_o;
    logic [31:0] fetch_cnt_o;
    logic        trap_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;

    ifetch #(.RESET_PC(RST_PC)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .pc_next_sel_i(pc_next_sel_i), .pc_next_off_i(pc_next_off_i), .pc_target_i(pc_target_i),
        .pc_o(pc_o), .pc_data_o(pc_data_o), .instr_valid_o(instr_valid_o),
        .fetch_cnt_o(fetch_cnt_o), .trap_o(trap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc_o, RST_PC);
        chk({tag, "_req"}, {31'd0, imem_req_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
        chk({tag, "_data"}, pc_data_o, NOP);
        chk({tag, "_cnt"}, fetch_cnt_o, 32'd0);
        chk({tag, "_trap"}, {31'd0, trap_o}, 32'd0);
    endtask

    // Called with the DUT in the request cycle; serves one fetch with the given waits.
    task automatic do_fetch(input int gdly, input int rdly, input logic [31:0] d);
        for (int i = 0; i < gdly; i++) begin
            chk("gw_req", {31'd0, imem_req_o}, 32'd1);
            chk("gw_addr", imem_addr_o, exp_pc);
            chk("gw_data", pc_data_o, NOP);
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'($urandom_range(0, 1));
            imem_rdata_i  = $urandom;
            step();
        end
        chk("req", {31'd0, imem_req_o}, 32'd1);
        chk("addr", imem_addr_o, exp_pc);
        chk("req_valid", {31'd0, instr_valid_o}, 32'd0);
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'($urandom_range(0, 1));
        imem_rdata_i  = $urandom;
        step();
        for (int i = 0; i < rdly; i++) begin
            chk("rw_req", {31'd0, imem_req_o}, 32'd0);
            chk("rw_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("rw_data", pc_data_o, NOP);
            imem_gnt_i    = 1'($urandom_range(0, 1));
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            step();
        end
        chk("w_data", pc_data_o, NOP);
        imem_gnt_i    = 1'($urandom_range(0, 1));
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = d;
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        chk("valid", {31'd0, instr_valid_o}, 32'd1);
        chk("data", pc_data_o, d);
        chk("pc", pc_o, exp_pc);
        chk("v_req", {31'd0, imem_req_o}, 32'd0);
    endtask

    // Called in the valid state; issues one redirect and updates the model.
    task automatic redirect(input logic [1:0] sel, input logic [31:0] off, input logic [31:0] tgt,
                            output bit trapped);
        logic [31:0] nxt;
        pc_next_sel_i = sel;
        pc_next_off_i = off;
        pc_target_i   = tgt;
        nxt = (sel == 2'd1) ? exp_pc + off : {tgt[31:1], 1'b0};
        exp_cnt = exp_cnt + 1;
        trapped = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        trapped = (nxt[1:0] != 2'b00);
        exp_pc  = nxt;
`else
        exp_pc  = {nxt[31:2], 2'b00};
`endif
        step();
        pc_next_sel_i = 2'd0;
        chk("rd_pc", pc_o, exp_pc);
        chk("rd_cnt", fetch_cnt_o, exp_cnt);
        chk("rd_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rd_data", pc_data_o, NOP);
        chk("rd_req", {31'd0, imem_req_o}, {31'd0, !trapped});
        chk("rd_trap", {31'd0, trap_o}, {31'd0, trapped});
    endtask

    task automatic stall(input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            pc_next_sel_i = ($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3;
            pc_next_off_i = $urandom;
            pc_target_i   = $urandom;
            imem_gnt_i    = 1'($urandom_range(0, 1));
            imem_rvalid_i = 1'($urandom_range(0, 1));
            imem_rdata_i  = $urandom;
            step();
            chk("st_pc", pc_o, exp_pc);
            chk("st_data", pc_data_o, d);
            chk("st_cnt", fetch_cnt_o, exp_cnt);
            chk("st_req", {31'd0, imem_req_o}, 32'd0);
            chk("st_valid", {31'd0, instr_valid_o}, 32'd1);
        end
        pc_next_sel_i = 2'd0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d, off, tgt;
        logic [1:0]  sel;
        bit          tr;

        // Reset state and first fetch with zero-wait memory.
        exp_pc  = RST_PC;
        exp_cnt = 0;
        step();
        chk_reset_vals("rst");
        step();
        rstn_i = 1'b1;
        chk("c1_req", {31'd0, imem_req_o}, 32'd0);
        step();
        do_fetch(0, 0, 32'h0050_0093);

        // PC_IMM with a negative offset wraps down to 0xF8.
        redirect(2'd1, 32'hFFFF_FFF8, 32'h0, tr);
        chk("neg_off_addr", imem_addr_o, 32'h0000_00F8);
        d = $urandom;
        do_fetch(3, 2, d);

        // Ten stall cycles hold everything.
        stall(10, d);

        // Randomized redirects and memory latencies.
        for (int k = 0; k < 25; k++) begin
            sel = 2'($urandom_range(1, 2));
            off = $urandom;
            tgt = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
            off = off & ~32'h3;
            tgt = tgt & ~32'h3;
`endif
            redirect(sel, off, tgt, tr);
            d = $urandom;
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3), d);
            stall($urandom_range(0, 2), d);
        end

        // Reset while waiting for rvalid, then a stale rvalid in the request phase.
        redirect(2'd2, 32'h0, 32'h0000_0440, tr);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("pre_rst_req", {31'd0, imem_req_o}, 32'd0);
        rstn_i = 1'b0;
        #1;
        exp_pc  = RST_PC;
        exp_cnt = 0;
        chk_reset_vals("mid_rst");
        step();
        rstn_i        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        step();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_BAD0;
        step();
        imem_rvalid_i = 1'b0;
        chk("stale_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("stale_data", pc_data_o, NOP);
        chk("stale_addr", imem_addr_o, RST_PC);
        do_fetch(0, 1, 32'h1234_5678);

        // ABS with an address whose bit 1 is set.
        redirect(2'd2, 32'h0, 32'h0000_0202, tr);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("trap_pc", pc_o, 32'h0000_0202);
        for (int i = 0; i < 5; i++) begin
            imem_gnt_i    = 1'($urandom_range(0, 1));
            imem_rvalid_i = 1'($urandom_range(0, 1));
            pc_next_sel_i = 2'($urandom_range(1, 2));
            step();
            chk("trap_hold", {31'd0, trap_o}, 32'd1);
            chk("trap_req", {31'd0, imem_req_o}, 32'd0);
            chk("trap_valid", {31'd0, instr_valid_o}, 32'd0);
            chk("trap_pc_hold", pc_o, 32'h0000_0202);
        end
        pc_next_sel_i = 2'd0;
`else
        chk("abs_addr", imem_addr_o, 32'h0000_0200);
        do_fetch(1, 0, 32'hCAFE_0013);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
